pipe_stage_reg: RTL

- Generic, parametrised pipeline stage register. It is the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload and a control payload between stages with a valid/ready handshake, flush (bubble insertion) and an optional 2-entry skid buffer that registers the backpressure path.
- Control bits are forced to zero whenever the stage holds a bubble. Write-enables and branch signals therefore never leak from squashed instructions.

---
 rtl/pipe_stage_reg_pkg.sv | 29 ++
 rtl/pipe_stage_reg.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipe_stage_reg: default payload widths, the FSM state
// encoding and the main-entry load select used by the stage register.
package pipe_stage_reg_pkg;

  // Defaults shared with the per-stage wrappers so every stage agrees on widths.
  localparam int unsigned DEF_DATA_W = 96;
  localparam int unsigned DEF_CTRL_W = 24;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MAIN_HOLD = 2'd0,
    MAIN_IN   = 2'd1,
    MAIN_SKID = 2'd2
  } main_sel_e;

  function automatic logic [1:0] state_occupancy(input state_e s);
    case (s)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and an optional
// 2-entry skid buffer; control payload is masked to zero on bubbles.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  state_e      state_q, state_d;
  main_sel_e   main_sel;
  logic        skid_load;
  logic        in_fire;
  logic        in_ready_q;

  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;

  assign in_fire = in_valid_i & in_ready_o;

  // State register; in_ready is precomputed from the next state so that the
  // skid build presents a flop-driven ready upstream.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Next-state logic. With SKID=0 in_ready tracks out_ready in BUSY, so the
  // BUSY->FULL arc can never be taken and the FSM degenerates to one entry.
  // NOTE: every output of this block gets a default first, otherwise paths
  // that do not assign it would infer latches.
  always_comb begin
    state_d   = state_q;
    main_sel  = MAIN_HOLD;
    skid_load = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d  = ST_BUSY;
            main_sel = MAIN_IN;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_ready_i) begin
            main_sel = MAIN_IN;
          end else if (in_fire) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (out_ready_i) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready_i) begin
            state_d  = ST_BUSY;
            main_sel = MAIN_SKID;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Outputs: valid and occupancy come straight from the state; control is
  // masked so squashed instructions never present write-enables or branches.
  always_comb begin
    out_valid_o = (state_q != ST_EMPTY);
    occupancy_o = state_occupancy(state_q);
    in_ready_o  = SKID ? in_ready_q : (!out_valid_o || out_ready_i);
    out_data_o  = main_data_q;
    out_ctrl_o  = main_ctrl_q & {CTRL_W{out_valid_o}};
  end

  // Payload registers. On flush only the control halves are cleared; data may
  // stay stale because it is never observed without out_valid_o.
  // NOTE: the payload registers are reset even though they act as storage,
  // because out_data_o must read zero straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush_i) begin
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (main_sel)
        MAIN_IN: begin
          main_data_q <= in_data_i;
          main_ctrl_q <= in_ctrl_i;
        end
        MAIN_SKID: begin
          main_data_q <= skid_data_q;
          main_ctrl_q <= skid_ctrl_q;
        end
        default: ;
      endcase
      if (skid_load) begin
        skid_data_q <= in_data_i;
        skid_ctrl_q <= in_ctrl_i;
      end
    end
  end

endmodule
